// File: rtl/jtag_uart_avalon.sv
`default_nettype none
// ============================================================================
// Module      : jtag_uart_avalon
// Description : Avalon-MM console UART with DATA/CONTROL registers, TX/RX byte
//               FIFOs towards the host and a threshold-based level interrupt.
// Revision    : 1.0 - initial release
// ============================================================================
module jtag_uart_avalon #(
    parameter int WR_DEPTH  = 64,
    parameter int RD_DEPTH  = 64,
    parameter int WR_THRESH = 8,
    parameter int RD_THRESH = 8
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    input  logic        av_chipselect,
    input  logic        av_address,
    input  logic        av_read_n,
    input  logic        av_write_n,
    input  logic [31:0] av_writedata,
    output logic [31:0] av_readdata,
    output logic        av_waitrequest,
    output logic        irq_irq,
    input  logic        host_rx_valid,
    input  logic [7:0]  host_rx_data,
    output logic        host_rx_ready,
    output logic        host_tx_valid,
    output logic [7:0]  host_tx_data,
    input  logic        host_tx_ready
);

    localparam int WR_AW = $clog2(WR_DEPTH);
    localparam int RD_AW = $clog2(RD_DEPTH);
    localparam logic [15:0] c_wr_depth  = 16'(WR_DEPTH);
    localparam logic [15:0] c_rd_depth  = 16'(RD_DEPTH);
    localparam logic [15:0] c_wr_thresh = 16'(WR_THRESH);
    localparam logic [15:0] c_rd_thresh = 16'(RD_THRESH);

    logic             r_ack, r_re, r_we, r_ac;
    logic [7:0]       r_tx_mem [WR_DEPTH];
    logic [WR_AW-1:0] r_tx_wp, r_tx_rp;
    logic [15:0]      r_tx_cnt;
    logic [7:0]       r_rx_mem [RD_DEPTH];
    logic [RD_AW-1:0] r_rx_wp, r_rx_rp;
    logic [15:0]      r_rx_cnt;

    logic        w_complete, w_wr, w_rd;
    logic        w_tx_push, w_tx_pop, w_rx_push, w_rx_pop;
    logic        w_ri, w_wi;
    logic [15:0] w_wspace;
    logic        w_unused_wdata;

    // Every access stalls exactly one cycle; the ack cycle is the completion.
    assign w_complete = av_chipselect & r_ack;
    assign w_wr       = w_complete & ~av_write_n;
    assign w_rd       = w_complete & av_write_n & ~av_read_n;

    assign w_tx_push = w_wr & ~av_address & (r_tx_cnt < c_wr_depth);
    assign w_tx_pop  = host_tx_valid & host_tx_ready;
    assign w_rx_push = host_rx_valid & host_rx_ready;
    assign w_rx_pop  = w_rd & ~av_address & (r_rx_cnt != 16'd0);

    assign w_ri     = r_re & (r_rx_cnt >= c_rd_thresh);
    assign w_wi     = r_we & (r_tx_cnt <= c_wr_thresh);
    assign w_wspace = c_wr_depth - r_tx_cnt;

    assign av_waitrequest = av_chipselect & ~r_ack;
    assign irq_irq        = w_ri | w_wi;
    assign host_rx_ready  = r_rx_cnt < c_rd_depth;
    assign host_tx_valid  = r_tx_cnt != 16'd0;
    assign host_tx_data   = r_tx_mem[r_tx_rp];

    assign w_unused_wdata = ^{av_writedata[31:11], av_writedata[9:2]};

    always_comb begin
        av_readdata = 32'd0;
        if (w_rd) begin
            if (av_address)
                av_readdata = {w_wspace, 5'b0, r_ac, w_wi, w_ri, 6'b0, r_we, r_re};
            else if (r_rx_cnt != 16'd0)
                av_readdata = {r_rx_cnt - 16'd1, 1'b1, 7'b0, r_rx_mem[r_rx_rp]};
        end
    end

    // Storage arrays carry no reset; only pointers and counts define contents.
    always_ff @(posedge clk_clk) begin
        if (w_tx_push) r_tx_mem[r_tx_wp] <= av_writedata[7:0];
        if (w_rx_push) r_rx_mem[r_rx_wp] <= host_rx_data;
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_ack    <= 1'b0;
            r_re     <= 1'b0;
            r_we     <= 1'b0;
            r_ac     <= 1'b0;
            r_tx_wp  <= '0;
            r_tx_rp  <= '0;
            r_tx_cnt <= 16'd0;
            r_rx_wp  <= '0;
            r_rx_rp  <= '0;
            r_rx_cnt <= 16'd0;
        end else begin
            r_ack <= av_chipselect & ~r_ack;

            if (w_wr && av_address) begin
                r_re <= av_writedata[0];
                r_we <= av_writedata[1];
            end
            // A host handshake in the same cycle as a clear keeps AC set.
            if (w_tx_pop)
                r_ac <= 1'b1;
            else if (w_wr && av_address && av_writedata[10])
                r_ac <= 1'b0;

            if (w_tx_push) r_tx_wp <= r_tx_wp + WR_AW'(1);
            if (w_tx_pop)  r_tx_rp <= r_tx_rp + WR_AW'(1);
            if (w_tx_push && !w_tx_pop)
                r_tx_cnt <= r_tx_cnt + 16'd1;
            else if (!w_tx_push && w_tx_pop)
                r_tx_cnt <= r_tx_cnt - 16'd1;

            if (w_rx_push) r_rx_wp <= r_rx_wp + RD_AW'(1);
            if (w_rx_pop)  r_rx_rp <= r_rx_rp + RD_AW'(1);
            if (w_rx_push && !w_rx_pop)
                r_rx_cnt <= r_rx_cnt + 16'd1;
            else if (!w_rx_push && w_rx_pop)
                r_rx_cnt <= r_rx_cnt - 16'd1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_jtag_uart_avalon.sv
`default_nettype none
// ============================================================================
// Module      : tb_jtag_uart_avalon
// Description : Self-checking bench; queue-based reference model checked each
//               cycle, plus directed register-level scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_jtag_uart_avalon;

    logic        clk_clk = 1'b0;
    logic        reset_reset_n;
    logic        av_chipselect, av_address, av_read_n, av_write_n;
    logic [31:0] av_writedata;
    logic [31:0] av_readdata;
    logic        av_waitrequest, irq_irq;
    logic        host_rx_valid;
    logic [7:0]  host_rx_data;
    logic        host_rx_ready, host_tx_valid;
    logic [7:0]  host_tx_data;
    logic        host_tx_ready;

    jtag_uart_avalon dut (
        .clk_clk        (clk_clk),
        .reset_reset_n  (reset_reset_n),
        .av_chipselect  (av_chipselect),
        .av_address     (av_address),
        .av_read_n      (av_read_n),
        .av_write_n     (av_write_n),
        .av_writedata   (av_writedata),
        .av_readdata    (av_readdata),
        .av_waitrequest (av_waitrequest),
        .irq_irq        (irq_irq),
        .host_rx_valid  (host_rx_valid),
        .host_rx_data   (host_rx_data),
        .host_rx_ready  (host_rx_ready),
        .host_tx_valid  (host_tx_valid),
        .host_tx_data   (host_tx_data),
        .host_tx_ready  (host_tx_ready)
    );

    always #5 clk_clk = ~clk_clk;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [7:0]  tx_q[$];
    logic [7:0]  rx_q[$];
    bit          m_re, m_we, m_ac, m_ack;
    logic [31:0] last_rdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic model_reset();
        tx_q.delete();
        rx_q.delete();
        m_re = 0; m_we = 0; m_ac = 0; m_ack = 0;
    endtask

    // Predict outputs from model state and current inputs, then advance the model.
    task automatic model_cycle();
        int txn, rxn;
        bit comp, is_wr, is_rd, ri, wi;
        logic [31:0] erd;
        txn = tx_q.size();
        rxn = rx_q.size();
        comp  = av_chipselect && m_ack;
        is_wr = comp && !av_write_n;
        is_rd = comp && av_write_n && !av_read_n;
        ri = m_re && (rxn >= 8);
        wi = m_we && (txn <= 8);
        erd = 32'd0;
        if (is_rd && av_address)
            erd = {16'(64 - txn), 5'b0, m_ac, wi, ri, 6'b0, m_we, m_re};
        else if (is_rd && rxn > 0)
            erd = {16'(rxn - 1), 1'b1, 7'b0, rx_q[0]};
        chk("waitrequest", av_waitrequest, av_chipselect && !m_ack);
        chk("readdata", av_readdata, erd);
        chk("irq", irq_irq, ri || wi);
        chk("rx_ready", host_rx_ready, rxn < 64);
        chk("tx_valid", host_tx_valid, txn != 0);
        if (txn != 0) chk("tx_data", host_tx_data, tx_q[0]);
        if (comp) last_rdata = av_readdata;

        if (is_wr && av_address) begin
            m_re = av_writedata[0];
            m_we = av_writedata[1];
            if (av_writedata[10]) m_ac = 0;
        end
        if (txn != 0 && host_tx_ready) begin
            void'(tx_q.pop_front());
            m_ac = 1;
        end
        if (is_wr && !av_address && txn < 64) tx_q.push_back(av_writedata[7:0]);
        if (is_rd && !av_address && rxn > 0) void'(rx_q.pop_front());
        if (host_rx_valid && rxn < 64) rx_q.push_back(host_rx_data);
        m_ack = av_chipselect && !m_ack;
    endtask

    task automatic step();
        @(negedge clk_clk);
        if (!reset_reset_n) begin
            model_reset();
            chk("rst_wait", av_waitrequest, av_chipselect);
            chk("rst_rdata", av_readdata, 32'd0);
            chk("rst_irq", irq_irq, 0);
            chk("rst_rx_ready", host_rx_ready, 1);
            chk("rst_tx_valid", host_tx_valid, 0);
        end else begin
            model_cycle();
        end
        @(posedge clk_clk);
        #1;
    endtask

    task automatic bus(input bit a, input bit wr, input logic [31:0] d);
        av_chipselect = 1; av_address = a; av_write_n = !wr; av_read_n = wr; av_writedata = d;
        step();
        step();
        av_chipselect = 0; av_write_n = 1; av_read_n = 1;
    endtask

    task automatic host_push(input logic [7:0] b);
        host_rx_valid = 1; host_rx_data = b;
        step();
        host_rx_valid = 0;
    endtask

    initial begin
        int got;
        av_chipselect = 0; av_address = 0; av_read_n = 1; av_write_n = 1; av_writedata = 0;
        host_rx_valid = 0; host_rx_data = 0; host_tx_ready = 0;
        reset_reset_n = 0;
        model_reset();
        step(); step();
        reset_reset_n = 1;
        step();

        // Plain DATA read after reset
        bus(0, 0, 0);
        chk("t1_rdata", last_rdata, 32'h0);
        chk("t1_irq", irq_irq, 0);

        // Host bytes read back through DATA
        host_push(8'h41);
        host_push(8'h42);
        bus(0, 0, 0); chk("t2_rd1", last_rdata, 32'h0001_8041);
        bus(0, 0, 0); chk("t2_rd2", last_rdata, 32'h0000_8042);
        bus(0, 0, 0); chk("t2_rd3", last_rdata, 32'h0);

        // CPU byte to host, AC sticky then cleared
        bus(0, 1, 32'h55);
        bus(1, 0, 0);
        chk("t3_wspace", last_rdata[31:16], 63);
        chk("t3_tx_valid", host_tx_valid, 1);
        chk("t3_tx_data", host_tx_data, 8'h55);
        host_tx_ready = 1; step(); host_tx_ready = 0;
        bus(1, 0, 0); chk("t3_ac_set", last_rdata[10], 1);
        bus(1, 1, 32'h400);
        bus(1, 0, 0); chk("t3_ac_clr", last_rdata[10], 0);

        // Overfill TX, then drain in order
        for (int i = 0; i < 65; i++) bus(0, 1, 32'(i));
        bus(1, 0, 0); chk("t4_wspace", last_rdata[31:16], 0);
        host_tx_ready = 1;
        got = 0;
        for (int c = 0; c < 200 && host_tx_valid; c++) begin
            chk("t4_order", host_tx_data, 8'(got));
            got++;
            step();
        end
        host_tx_ready = 0;
        chk("t4_count", got, 64);

        // Read-threshold interrupt
        bus(1, 1, 32'h1);
        for (int i = 0; i < 8; i++) begin
            chk("t5_irq_pre", irq_irq, 0);
            host_push(8'(8'hA0 + i));
        end
        chk("t5_irq_up", irq_irq, 1);
        bus(1, 0, 0); chk("t5_ri", last_rdata[8], 1);
        bus(0, 0, 0); chk("t5_rd", last_rdata, 32'h0007_80A0);
        chk("t5_irq_down", irq_irq, 0);
        for (int i = 0; i < 7; i++) bus(0, 0, 0);

        // Write-threshold interrupt
        bus(1, 1, 32'h2);
        chk("t6_irq_empty", irq_irq, 1);
        bus(1, 0, 0); chk("t6_wi", last_rdata[9], 1);
        for (int i = 0; i < 9; i++) bus(0, 1, 32'(8'hC0 + i));
        chk("t6_irq_9", irq_irq, 0);
        host_tx_ready = 1; step(); host_tx_ready = 0;
        chk("t6_irq_8", irq_irq, 1);

        // Reset in the middle of an access restarts it from the wait cycle
        host_push(8'h77);
        av_chipselect = 1; av_address = 0; av_read_n = 0; av_write_n = 1;
        step();
        reset_reset_n = 0;
        #1;
        model_reset();
        chk("mr_wait", av_waitrequest, 1);
        chk("mr_tx_valid", host_tx_valid, 0);
        step();
        reset_reset_n = 1;
        step(); step();
        chk("mr_rdata", last_rdata, 32'h0);
        av_chipselect = 0; av_read_n = 1;
        bus(1, 0, 0); chk("mr_ctrl", last_rdata, 32'h0040_0000);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            host_rx_valid = ($urandom_range(0, 2) != 0);
            host_rx_data  = 8'($urandom);
            host_tx_ready = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 3))
                0, 1: bus(1'($urandom), 1'($urandom), $urandom & 32'h0000_04FF);
                2:    bus(0, 1'($urandom), $urandom);
                default: step();
            endcase
        end
        host_rx_valid = 0; host_tx_ready = 0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/jtag_uart_avalon.md
# jtag_uart_avalon

Avalon-MM slave byte-stream UART that gives the CPU data bus a console channel. The bus side offers a DATA and a CONTROL register. The host side offers two byte streams with valid/ready handshakes, one in each direction, each buffered by its own FIFO. The block sits on the CPU peripheral bus in the 0x9xxx_xxxx decode region and raises a level interrupt based on FIFO thresholds.

## Interface
Parameters:
- WR_DEPTH, 64: TX FIFO depth (CPU→host); power of two, 2..32768.
- RD_DEPTH, 64: RX FIFO depth (host→CPU); power of two, 2..32768.
- WR_THRESH, 8: write-interrupt condition is TX count ≤ WR_THRESH.
- RD_THRESH, 8: read-interrupt condition is RX count ≥ RD_THRESH.

Ports:
- clk_clk, in, 1: sole clock; all logic is on the rising edge.
- reset_reset_n, in, 1: reset, asynchronous and active-low.
- av_chipselect, in, 1: access request; held stable while av_waitrequest is high.
- av_address, in, 1: register select; 0 = DATA, 1 = CONTROL.
- av_read_n, in, 1: read strobe, active-low.
- av_write_n, in, 1: write strobe, active-low.
- av_writedata, in, 32: write data.
- av_readdata, out, 32: read data; valid in the completion cycle.
- av_waitrequest, out, 1: access stall.
- irq_irq, out, 1: level interrupt.
- host_rx_valid, in, 1: host offers a byte for the CPU.
- host_rx_data, in, 8: byte offered by the host.
- host_rx_ready, out, 1: RX FIFO can accept a byte.
- host_tx_valid, out, 1: TX FIFO has a byte for the host.
- host_tx_data, out, 8: byte at the TX FIFO head.
- host_tx_ready, in, 1: host accepts the TX byte.

## Operation
Access sequencing:
- Internal ack flag.
- av_waitrequest = av_chipselect & ~ack.
- ack sets on a cycle with chipselect and ack = 0, and clears in the following cycle.
- The completion cycle is the cycle with chipselect = 1 and ack = 1. Every access completes in exactly 2 cycles.
- All side effects happen in the completion cycle only.
- If both strobes are asserted, the write wins. If neither is asserted, the access completes with no effect.

DATA register read:
- Bit assignment: [7:0] = RX head byte, [15] = RVALID (RX FIFO non-empty), [14:8] = 0, [31:16] = RAVAIL.
- RAVAIL is the RX count after this read.
- Pops one RX byte if the FIFO is non-empty.
- Empty FIFO: returns 0x0000_0000 and does not pop.

DATA register write:
- Pushes av_writedata[7:0] into the TX FIFO if count < WR_DEPTH.
- Otherwise the byte is silently dropped.

CONTROL register read:
- Bit assignment: [0] RE, [1] WE, [8] RI, [9] WI, [10] AC, [31:16] WSPACE; all other bits 0.
- RE, WE: interrupt enables.
- RI = RE & (RX count ≥ RD_THRESH).
- WI = WE & (TX count ≤ WR_THRESH).
- AC: sticky; sets on every host_tx handshake.
- WSPACE = WR_DEPTH − TX count.

CONTROL register write:
- RE ← wdata[0], WE ← wdata[1].
- wdata[10] = 1 clears AC. A simultaneous host_tx handshake wins, so AC stays 1.

Interrupt: irq_irq = RI | WI, combinational from registered state.

Host side:
- host_rx_ready = RX count < RD_DEPTH. A push occurs on valid & ready.
- host_tx_valid = TX count ≠ 0, and host_tx_data = TX head. A pop occurs on valid & ready.

FIFO rules:
- A push and a pop in the same cycle on one FIFO both occur; the count is unchanged.
- The full test uses the count at the start of the cycle.
- Pointers wrap modulo depth. Counts are 16-bit, saturating impossible by construction.

## Timing
- Reset values:
  - FIFOs empty.
  - RE = WE = AC = ack = 0.
  - av_readdata = 0, irq_irq = 0.
  - host_tx_valid = 0, host_rx_ready = 1.
  - av_waitrequest follows av_chipselect.
- av_readdata is combinational in the completion cycle and 0 in all other cycles.
- State changes from a completion cycle are visible from the next cycle. This includes FIFO counts, RE/WE/AC and irq.
- A host byte pushed in cycle N is readable by a DATA read whose completion cycle is N+1 or later.
- Back-to-back accesses: after a completion cycle, ack = 0, so the next access again stalls one cycle.
- Reset asserted mid-access: state clears immediately, and the access restarts from its wait cycle after reset is released.

## Test plan
- Reset, then one DATA read: waitrequest is 1 for one cycle, then 0. readdata = 0x0000_0000 and irq = 0.
- Host pushes 0x41, 0x42, then two DATA reads. Reads return 0x0001_8041 then 0x0000_8042, and a third read returns 0.
- CPU writes 0x55 to DATA. WSPACE reads 63, host_tx_valid = 1 with data 0x55. Host accepts it: AC = 1. A CONTROL write of 0x400 clears AC.
- With WR_DEPTH = 64, write 65 bytes to DATA. The 65th is dropped, WSPACE = 0, and host drain yields exactly 64 bytes in order.
- Write CONTROL = 0x1, then host pushes 8 bytes. irq rises the cycle after the 8th push. CONTROL reads RI = 1. Reading one byte drops irq.
- Write CONTROL = 0x2 with the TX FIFO empty. irq = 1 and WI = 1. After 9 DATA writes irq = 0. Draining to 8 bytes reasserts irq.
